// File: rtl/rb_mem_ctrl.sv
// Memory-transfer sequencer for the register bank's working register (R34):
// runs one memory micro-op at a time with a req/ack handshake and a timeout.
module rb_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uop_valid,
  input  logic        uop_rd,
  input  logic [15:0] uop_addr,
  input  logic [15:0] wr_data,
  output logic        stall,
  output logic [1:0]  rb_mc,
  output logic [15:0] rb_mdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ISSUE,
    S_WBACK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] MC_NONE     = 2'b00;
  localparam logic [1:0] MC_LATCH_WR = 2'b01;
  localparam logic [1:0] MC_LOAD_WR  = 2'b10;

  // Counter value seen during the last ISSUE cycle before an abort.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [15:0] addr_q;
  logic        rd_q;
  logic [7:0]  to_cnt;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (uop_valid) next_state = uop_rd ? S_ISSUE : S_PREP;
      S_PREP:  next_state = S_ISSUE;
      S_ISSUE: begin
        // An ack in the expiry cycle still completes the operation.
        if (mem_ack)                 next_state = rd_q ? S_WBACK : S_DONE;
        else if (to_cnt == TO_LAST)  next_state = S_ERROR;
      end
      S_WBACK: next_state = S_DONE;
      S_DONE,
      S_ERROR: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    rb_mc   = MC_NONE;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      S_IDLE:  stall = uop_valid;
      S_PREP:  begin stall = 1'b1; rb_mc = MC_LATCH_WR; end
      S_ISSUE: begin stall = 1'b1; mem_req = 1'b1; mem_we = ~rd_q; end
      S_WBACK: begin stall = 1'b1; rb_mc = MC_LOAD_WR; end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wr_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      to_cnt   <= '0;
      rb_mdata <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && uop_valid) begin
        addr_q <= uop_addr;
        rd_q   <= uop_rd;
      end
      // Held at zero outside ISSUE, so it is always clear on entry.
      to_cnt <= (state == S_ISSUE && !mem_ack) ? to_cnt + 8'd1 : 8'd0;
      if (state == S_ISSUE && mem_ack && rd_q) rb_mdata <= mem_rdata;
      if (state == S_ISSUE && next_state == S_ERROR) err <= 1'b1;
      else if (err_clr)                             err <= 1'b0;
    end
  end

endmodule

// File: doc/rb_mem_ctrl.md
# rb_mem_ctrl

Memory-transfer sequencer for the register bank's working register (R34). It accepts one memory micro-operation at a time from the microsequencer and stalls the microsequencer while the operation runs. It drives the bank's MC control field (bit0 MW, bit1 MR) and runs a req/ack handshake with data memory. A missing ack within a timeout aborts the operation and sets a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 15, maximum ISSUE cycles without mem_ack before abort (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- uop_valid  in  1  microinstruction requests a memory op; held until stall drops
- uop_rd  in  1  1 = read memory into WR, 0 = write WR to memory
- uop_addr  in  16  memory word address
- wr_data  in  16  register bank WRdata output
- stall  out  1  freeze microsequencer
- rb_mc  out  2  to register bank MC: 01 = latch WR into WRdata, 10 = load Mdata into WR
- rb_mdata  out  16  to register bank Mdata
- mem_req  out  1  memory request
- mem_we  out  1  1 = write cycle
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in ISSUE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

## Operation
- States: IDLE, PREP, ISSUE, WBACK, DONE, ERROR. Outputs are Moore-decoded from the state and the registers. The one exception is stall in IDLE.
- IDLE:
  - stall = uop_valid.
  - When uop_valid = 1, latch uop_addr into addr_q and uop_rd into rd_q.
  - Next state is ISSUE if uop_rd = 1, else PREP.
- PREP (write only): rb_mc = 01 for one cycle, so the bank latches WR into WRdata at this edge. Next state is ISSUE.
- ISSUE:
  - Drive mem_req = 1, mem_we = ~rd_q, mem_addr = addr_q. mem_wdata = wr_data passes through; WRdata stays stable because rb_mc = 00.
  - Timeout counter is cleared on entry and increments each ISSUE cycle without ack.
  - mem_ack = 1, read: capture mem_rdata into rb_mdata, go to WBACK.
  - mem_ack = 1, write: go to DONE.
  - Counter reaches TIMEOUT with no ack: go to ERROR and set err.
- WBACK: rb_mc = 10 for one cycle, so WR loads rb_mdata. Next state is DONE.
- DONE: stall = 0 for one cycle; uop_valid is ignored. Next state is IDLE.
- ERROR: stall = 0 for one cycle; uop_valid is ignored; WR is not modified. Next state is IDLE.
- err is set on entry to ERROR and cleared by err_clr. If both happen in the same cycle, set wins.
- stall = 1 in PREP, ISSUE and WBACK.
- rb_mc = 00 in every state except PREP and WBACK; the values 01 and 10 never overlap.
- mem_req = 0 outside ISSUE.
- mem_addr holds addr_q in all states. Changes to uop_addr or uop_rd after acceptance have no effect.

## Timing
- Reset (asynchronous, immediate, including mid-operation): state IDLE, stall = 0 unless uop_valid, rb_mc = 00, rb_mdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, err = 0, timeout counter = 0. mem_req drops in the same cycle rst_n falls.
- Minimum latency for both read and write, with ack in the first ISSUE cycle:
  - 4 cycles from the accept cycle (C0) to the end of DONE (C3).
  - stall is high in C0..C2 and low in C3.
  - The microsequencer advances at the C3 edge.
- Each extra wait cycle of mem_ack adds one stall cycle.
- Ack arriving in the same cycle the counter reaches TIMEOUT: ack wins and the operation completes normally.
- Abort timing: with no ack, ERROR is entered after exactly TIMEOUT ISSUE cycles.
- mem_ack outside ISSUE is ignored and has no state effect.
- Back-to-back operations: a new uop_valid is accepted in the IDLE cycle that follows DONE or ERROR. This gives a minimum spacing of 4 cycles between accepts.

## Test plan
- Read, addr 0x0123, mem_rdata 0xBEEF, ack in first ISSUE cycle:
  - mem_req is high 1 cycle with mem_we = 0.
  - rb_mc = 10 in C2 with rb_mdata = 0xBEEF.
  - stall high C0..C2, low C3.
- Write, addr 0x00F0, wr_data 0x5A5A, ack after 3 wait cycles:
  - rb_mc = 01 in C1.
  - mem_req high 4 cycles with mem_we = 1 and mem_wdata = 0x5A5A.
  - stall high 6 cycles total.
- Timeout, TIMEOUT = 4, no ack:
  - mem_req high exactly 4 cycles, then ERROR.
  - err = 1; stall low 1 cycle; rb_mc stays 00 throughout.
  - err_clr pulse then returns err to 0.
- Ack in the same cycle as the TIMEOUT expiry: normal completion, err stays 0.
- rst_n asserted mid-ISSUE of a read:
  - mem_req, stall and rb_mc go to 0 immediately.
  - No WBACK occurs.
  - The next uop_valid after reset is accepted cleanly.
- Back-to-back read then write with uop_valid held continuously:
  - uop_valid held high through DONE does not cause a re-accept in DONE.
  - The second op is accepted in the IDLE cycle after DONE, using the new uop_addr and uop_rd values.
